// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter unit for the ISA core. Computes the next program address
//   from the decoded pc_op, keeps a hardware return stack, and vectors to one
//   of NUM_IRQ prioritised interrupt handlers with single-level nesting guard.
//
// Ports
//   clk             system clock, rising edge
//   reset_bar       asynchronous active-low reset
//   advance         instruction-step enable; state moves only when high
//   pc_op           0 NEXT, 1 SKIP, 2 JUMP, 3 JUMP_W, 4 CALL, 5 RETURN,
//                   6 RETFIE, 7 reserved (behaves as NEXT)
//   skip_cond       ALU skip result, used with SKIP
//   literal         target for JUMP / CALL
//   wreg_addr       target for JUMP_W
//   irq, irq_en     level-sensitive requests and per-line enables
//   gie             global interrupt enable
//   clear_err       clears the sticky stack error flags
//   pc              current program address (registered)
//   stack_level     occupied return-stack entries (registered)
//   in_isr          interrupt handler active (registered)
//   irq_ack         one-hot, one-cycle acknowledge of the taken line
//   stack_overflow  sticky: push attempted while full
//   stack_underflow sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned PC_WIDTH      = 11,
  parameter int unsigned STACK_DEPTH   = 8,
  parameter int unsigned NUM_IRQ       = 4,
  parameter int unsigned VECTOR_BASE   = 4,
  parameter int unsigned VECTOR_STRIDE = 2
) (
  input  logic                               clk,
  input  logic                               reset_bar,
  input  logic                               advance,
  input  logic [2:0]                         pc_op,
  input  logic                               skip_cond,
  input  logic [PC_WIDTH-1:0]                literal,
  input  logic [PC_WIDTH-1:0]                wreg_addr,
  input  logic [NUM_IRQ-1:0]                 irq,
  input  logic [NUM_IRQ-1:0]                 irq_en,
  input  logic                               gie,
  input  logic                               clear_err,
  output logic [PC_WIDTH-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               in_isr,
  output logic [NUM_IRQ-1:0]                 irq_ack,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_SKIP   = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JUMP_W = 3'd3,
    OP_CALL   = 3'd4,
    OP_RETURN = 3'd5,
    OP_RETFIE = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } isr_state_e;

  // Architectural state
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [LVL_W-1:0]    r_level;
  isr_state_e          r_state;
  logic [NUM_IRQ-1:0]  r_ack;
  logic                r_ovf;
  logic                r_unf;

  // Combinational next-state terms
  op_e                 w_op;
  logic [PC_WIDTH-1:0] w_pc_inc1;
  logic [PC_WIDTH-1:0] w_pc_inc2;
  logic                w_full;
  logic                w_empty;
  logic [IDX_W-1:0]    w_top_idx;
  logic [IDX_W-1:0]    w_push_idx;
  logic [PC_WIDTH-1:0] w_top;
  logic [NUM_IRQ-1:0]  w_irq_pend;
  logic [IRQ_W-1:0]    w_irq_k;
  logic [PC_WIDTH-1:0] w_vector;
  logic [NUM_IRQ-1:0]  w_ack_onehot;
  logic [PC_WIDTH-1:0] w_flow_pc;
  logic                w_flow_ok;
  logic                w_call;
  logic                w_pop;
  logic                w_take;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_push;
  logic [PC_WIDTH-1:0] w_push_data;

  assign w_op       = op_e'(pc_op);
  assign w_pc_inc1  = r_pc + PC_WIDTH'(1);
  assign w_pc_inc2  = r_pc + PC_WIDTH'(2);
  assign w_full     = (r_level == LVL_W'(STACK_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_top_idx  = IDX_W'(r_level - LVL_W'(1));
  assign w_push_idx = IDX_W'(r_level);
  assign w_top      = r_stack[w_top_idx];
  assign w_irq_pend = irq & irq_en;

  // Lowest set request index wins (line 0 is highest priority)
  always_comb begin
    w_irq_k = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (w_irq_pend[i]) begin
        w_irq_k = IRQ_W'(i);
      end
    end
  end

  assign w_vector     = PC_WIDTH'(VECTOR_BASE + 32'(w_irq_k) * VECTOR_STRIDE);
  assign w_ack_onehot = NUM_IRQ'(1) << w_irq_k;

  // Flow result of the current op; stack ops are not interruptible this step
  always_comb begin
    w_flow_pc = w_pc_inc1;
    w_flow_ok = 1'b1;
    w_call    = 1'b0;
    w_pop     = 1'b0;
    case (w_op)
      OP_SKIP:   w_flow_pc = skip_cond ? w_pc_inc2 : w_pc_inc1;
      OP_JUMP:   w_flow_pc = literal;
      OP_JUMP_W: w_flow_pc = wreg_addr;
      OP_CALL: begin
        w_flow_pc = literal;
        w_flow_ok = 1'b0;
        w_call    = 1'b1;
      end
      OP_RETURN, OP_RETFIE: begin
        // Empty-stack pop falls through to the next instruction
        w_flow_pc = w_empty ? w_pc_inc1 : w_top;
        w_flow_ok = 1'b0;
        w_pop     = 1'b1;
      end
      default:   w_flow_pc = w_pc_inc1;
    endcase
  end

  assign w_take = gie && (r_state == ST_RUN) && (|w_irq_pend) && w_flow_ok;

  // An interrupt take pushes the flow result and redirects to the vector
  assign w_next_pc   = w_take ? w_vector : w_flow_pc;
  assign w_push      = w_call || w_take;
  assign w_push_data = w_take ? w_flow_pc : w_pc_inc1;

  // Return-stack storage; contents need no reset
  always_ff @(posedge clk) begin
    if (advance && w_push && !w_full) begin
      r_stack[w_push_idx] <= w_push_data;
    end
  end

  // PC, stack pointer, ISR state, acknowledge and sticky error flags
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_pc    <= '0;
      r_level <= '0;
      r_state <= ST_RUN;
      r_ack   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ack <= '0;
      // Clear first so an error raised on the same edge takes precedence
      if (clear_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (advance) begin
        r_pc <= w_next_pc;
        if (w_push) begin
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_level <= r_level + LVL_W'(1);
          end
        end else if (w_pop) begin
          if (w_empty) begin
            r_unf <= 1'b1;
          end else begin
            r_level <= r_level - LVL_W'(1);
          end
        end
        case (r_state)
          ST_RUN: begin
            if (w_take) begin
              r_state <= ST_ISR;
              r_ack   <= w_ack_onehot;
            end
          end
          ST_ISR: begin
            if (w_op == OP_RETFIE) begin
              r_state <= ST_RUN;
            end
          end
          default: r_state <= ST_RUN;
        endcase
      end
    end
  end

  assign pc              = r_pc;
  assign stack_level     = r_level;
  assign in_isr          = (r_state == ST_ISR);
  assign irq_ack         = r_ack;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer (PC_WIDTH=11, STACK_DEPTH=8,
//   NUM_IRQ=4, VECTOR_BASE=4, VECTOR_STRIDE=2). Each step record carries the
//   inputs and the outputs expected one clock later; expectations are queued
//   when a step is driven and compared after the advancing edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [2:0] NX = 3'd0, SK = 3'd1, JP = 3'd2, JW = 3'd3,
                         CL = 3'd4, RT = 3'd5, RF = 3'd6, RS = 3'd7;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        skip;
    logic [10:0] lit;
    logic [10:0] wreg;
    logic [3:0]  irq;
    logic [3:0]  en;
    logic        gie;
    logic        clr;
    logic        adv;
    logic [10:0] e_pc;
    logic [3:0]  e_lvl;
    logic        e_isr;
    logic [3:0]  e_ack;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic        clk;
  logic        reset_bar;
  logic        advance;
  logic [2:0]  pc_op;
  logic        skip_cond;
  logic [10:0] literal;
  logic [10:0] wreg_addr;
  logic [3:0]  irq;
  logic [3:0]  irq_en;
  logic        gie;
  logic        clear_err;
  logic [10:0] pc;
  logic [3:0]  stack_level;
  logic        in_isr;
  logic [3:0]  irq_ack;
  logic        stack_overflow;
  logic        stack_underflow;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  pc_sequencer #(
    .PC_WIDTH(11), .STACK_DEPTH(8), .NUM_IRQ(4), .VECTOR_BASE(4), .VECTOR_STRIDE(2)
  ) dut (
    .clk(clk), .reset_bar(reset_bar), .advance(advance), .pc_op(pc_op),
    .skip_cond(skip_cond), .literal(literal), .wreg_addr(wreg_addr),
    .irq(irq), .irq_en(irq_en), .gie(gie), .clear_err(clear_err),
    .pc(pc), .stack_level(stack_level), .in_isr(in_isr), .irq_ack(irq_ack),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // JUMP_W rows take their target in wreg; literal carries the complement so a
  // wrong source selection shows up (and vice versa for other ops)
  function automatic vec_t mk(string n, logic [2:0] op, logic sk, logic [10:0] tgt,
                              logic [3:0] rq, logic [3:0] en, logic g, logic c, logic a,
                              logic [10:0] epc, logic [3:0] el, logic ei, logic [3:0] ea,
                              logic eo, logic eu);
    vec_t v;
    v.name = n; v.op = op; v.skip = sk;
    if (op == JW) begin v.wreg = tgt; v.lit = ~tgt; end
    else          begin v.lit = tgt;  v.wreg = ~tgt; end
    v.irq = rq; v.en = en; v.gie = g; v.clr = c; v.adv = a;
    v.e_pc = epc; v.e_lvl = el; v.e_isr = ei; v.e_ack = ea; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", n, f, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard", "empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(e.name, "pc",    32'(pc),              32'(e.e_pc));
      chk(e.name, "level", 32'(stack_level),     32'(e.e_lvl));
      chk(e.name, "isr",   32'(in_isr),          32'(e.e_isr));
      chk(e.name, "ack",   32'(irq_ack),         32'(e.e_ack));
      chk(e.name, "ovf",   32'(stack_overflow),  32'(e.e_ovf));
      chk(e.name, "unf",   32'(stack_underflow), 32'(e.e_unf));
    end
  endtask

  task automatic apply(input vec_t v);
    pc_op = v.op; skip_cond = v.skip; literal = v.lit; wreg_addr = v.wreg;
    irq = v.irq; irq_en = v.en; gie = v.gie; clear_err = v.clr; advance = v.adv;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    vec_t v;
    logic [10:0] tgt;
    logic [10:0] ret_pc;

    reset_bar = 1'b0; advance = 1'b0; pc_op = NX; skip_cond = 1'b0;
    literal = '0; wreg_addr = '0; irq = '0; irq_en = 4'hF; gie = 1'b0; clear_err = 1'b0;

    // Sequential flow, stack, interrupts and error flags from reset
    tbl.push_back(mk("next1",      NX,0,11'h000,4'h0,4'hF,0,0,1, 11'h001,0,0,4'h0,0,0));
    tbl.push_back(mk("next2",      NX,0,11'h000,4'h0,4'hF,0,0,1, 11'h002,0,0,4'h0,0,0));
    tbl.push_back(mk("next3",      NX,0,11'h000,4'h0,4'hF,0,0,1, 11'h003,0,0,4'h0,0,0));
    tbl.push_back(mk("skip_t",     SK,1,11'h000,4'h0,4'hF,0,0,1, 11'h005,0,0,4'h0,0,0));
    tbl.push_back(mk("skip_f",     SK,0,11'h000,4'h0,4'hF,0,0,1, 11'h006,0,0,4'h0,0,0));
    tbl.push_back(mk("rsvd",       RS,1,11'h000,4'h0,4'hF,0,0,1, 11'h007,0,0,4'h0,0,0));
    tbl.push_back(mk("hold",       NX,0,11'h000,4'h0,4'hF,0,0,0, 11'h007,0,0,4'h0,0,0));
    tbl.push_back(mk("jump",       JP,0,11'h100,4'h0,4'hF,0,0,1, 11'h100,0,0,4'h0,0,0));
    tbl.push_back(mk("call1",      CL,0,11'h200,4'h0,4'hF,0,0,1, 11'h200,1,0,4'h0,0,0));
    tbl.push_back(mk("call2",      CL,0,11'h300,4'h0,4'hF,0,0,1, 11'h300,2,0,4'h0,0,0));
    tbl.push_back(mk("ret1",       RT,0,11'h000,4'h0,4'hF,0,0,1, 11'h201,1,0,4'h0,0,0));
    tbl.push_back(mk("ret2",       RT,0,11'h000,4'h0,4'hF,0,0,1, 11'h101,0,0,4'h0,0,0));
    tbl.push_back(mk("jmp_top",    JP,0,11'h7FF,4'h0,4'hF,0,0,1, 11'h7FF,0,0,4'h0,0,0));
    tbl.push_back(mk("wrap_next",  NX,0,11'h000,4'h0,4'hF,0,0,1, 11'h000,0,0,4'h0,0,0));
    tbl.push_back(mk("jmp_top2",   JP,0,11'h7FF,4'h0,4'hF,0,0,1, 11'h7FF,0,0,4'h0,0,0));
    tbl.push_back(mk("wrap_skip",  SK,1,11'h000,4'h0,4'hF,0,0,1, 11'h001,0,0,4'h0,0,0));
    tbl.push_back(mk("jump_w",     JW,0,11'h010,4'h0,4'hF,0,0,1, 11'h010,0,0,4'h0,0,0));
    tbl.push_back(mk("take_k1",    NX,0,11'h000,4'h6,4'hF,1,0,1, 11'h006,1,1,4'h2,0,0));
    tbl.push_back(mk("isr_block",  NX,0,11'h000,4'h1,4'hF,1,0,1, 11'h007,1,1,4'h0,0,0));
    tbl.push_back(mk("isr_call",   CL,0,11'h050,4'h1,4'hF,1,0,1, 11'h050,2,1,4'h0,0,0));
    tbl.push_back(mk("isr_ret",    RT,0,11'h000,4'h1,4'hF,1,0,1, 11'h008,1,1,4'h0,0,0));
    tbl.push_back(mk("retfie",     RF,0,11'h000,4'h0,4'hF,1,0,1, 11'h011,0,0,4'h0,0,0));
    tbl.push_back(mk("defer_call", CL,0,11'h040,4'h1,4'hF,1,0,1, 11'h040,1,0,4'h0,0,0));
    tbl.push_back(mk("take_after", NX,0,11'h000,4'h1,4'hF,1,0,1, 11'h004,2,1,4'h1,0,0));
    tbl.push_back(mk("retfie2",    RF,0,11'h000,4'h0,4'hF,0,0,1, 11'h041,1,0,4'h0,0,0));
    tbl.push_back(mk("ret_call",   RT,0,11'h000,4'h0,4'hF,0,0,1, 11'h012,0,0,4'h0,0,0));
    tbl.push_back(mk("masked",     NX,0,11'h000,4'h8,4'h7,1,0,1, 11'h013,0,0,4'h0,0,0));
    tbl.push_back(mk("gie_off",    NX,0,11'h000,4'h8,4'hF,0,0,1, 11'h014,0,0,4'h0,0,0));
    tbl.push_back(mk("take_jump",  JP,0,11'h020,4'h8,4'hF,1,0,1, 11'h00A,1,1,4'h8,0,0));
    tbl.push_back(mk("retfie3",    RF,0,11'h000,4'h0,4'hF,0,0,1, 11'h020,0,0,4'h0,0,0));
    tbl.push_back(mk("unf_ret",    RT,0,11'h000,4'h0,4'hF,0,0,1, 11'h021,0,0,4'h0,0,1));
    tbl.push_back(mk("unf_retfie", RF,0,11'h000,4'h0,4'hF,0,0,1, 11'h022,0,0,4'h0,0,1));
    tbl.push_back(mk("clr_hold",   NX,0,11'h000,4'h0,4'hF,0,1,0, 11'h022,0,0,4'h0,0,0));
    tbl.push_back(mk("take_k2",    NX,0,11'h000,4'h4,4'hF,1,0,1, 11'h008,1,1,4'h4,0,0));
    tbl.push_back(mk("ret_in_isr", RT,0,11'h000,4'h0,4'hF,0,0,1, 11'h023,0,1,4'h0,0,0));
    tbl.push_back(mk("retfie_emp", RF,0,11'h000,4'h0,4'hF,0,0,1, 11'h024,0,0,4'h0,0,1));
    tbl.push_back(mk("clr_adv",    NX,0,11'h000,4'h0,4'hF,0,1,1, 11'h025,0,0,4'h0,0,0));
    tbl.push_back(mk("clr_vs_err", RT,0,11'h000,4'h0,4'hF,0,1,1, 11'h026,0,0,4'h0,0,1));
    tbl.push_back(mk("clr_again",  NX,0,11'h000,4'h0,4'hF,0,1,0, 11'h026,0,0,4'h0,0,0));
    tbl.push_back(mk("adv0_irq",   NX,0,11'h000,4'h1,4'hF,1,0,0, 11'h026,0,0,4'h0,0,0));

    #12;
    exp_q.push_back(mk("reset", NX,0,11'h000,4'h0,4'hF,0,0,0, 11'h000,0,0,4'h0,0,0));
    check_out();
    #1 reset_bar = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Fill all eight stack entries
    for (int i = 0; i < 8; i++) begin
      tgt = 11'(32'h100 + 32'(i) * 32'h10);
      apply(mk($sformatf("fill%0d", i), CL,0,tgt,4'h0,4'hF,0,0,1, tgt,4'(i + 1),0,4'h0,0,0));
    end
    apply(mk("ovf_call",    CL,0,11'h400,4'h0,4'hF,0,0,1, 11'h400,8,0,4'h0,1,0));
    apply(mk("take_full",   NX,0,11'h000,4'h1,4'hF,1,0,1, 11'h004,8,1,4'h1,1,0));
    apply(mk("retfie_full", RF,0,11'h000,4'h0,4'hF,0,0,1, 11'h161,7,0,4'h0,1,0));
    // Unwind: entry i holds the return address of fill i
    for (int j = 0; j < 7; j++) begin
      ret_pc = (j == 6) ? 11'h027 : 11'(32'h100 + 32'(5 - j) * 32'h10 + 32'h1);
      apply(mk($sformatf("unwind%0d", j), RT,0,11'h000,4'h0,4'hF,0,0,1, ret_pc,4'(6 - j),0,4'h0,1,0));
    end

    // Async reset mid-ISR with three stacked entries and ack high
    apply(mk("pre_call1",  CL,0,11'h300,4'h0,4'hF,0,0,1, 11'h300,1,0,4'h0,1,0));
    apply(mk("pre_call2",  CL,0,11'h310,4'h0,4'hF,0,0,1, 11'h310,2,0,4'h0,1,0));
    apply(mk("pre_take",   NX,0,11'h000,4'h2,4'hF,1,0,1, 11'h006,3,1,4'h2,1,0));
    advance = 1'b0;
    #1 reset_bar = 1'b0;
    #1;
    exp_q.push_back(mk("async_rst", NX,0,11'h000,4'h0,4'hF,0,0,0, 11'h000,0,0,4'h0,0,0));
    check_out();
    #1 reset_bar = 1'b1;
    @(negedge clk);
    apply(mk("post_rst",   NX,0,11'h000,4'h0,4'hF,0,0,1, 11'h001,0,0,4'h0,0,0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
